// File: rtl/dbus_wbuf_ctrl_pkg.sv
// Shared encodings for the data-bus write-buffer controller: bus size codes,
// FSM states and a helper for sizing the ack wait counter.
package dbus_wbuf_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  // Width of a down-counter that must hold the value TIMEOUT (at least one bit).
  function automatic int wait_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/dbus_wbuf_ctrl_fifo.sv
// Synchronous store-buffer FIFO with a combinational head (dout = oldest entry).
// Push to a full FIFO and pop from an empty one are ignored.
module dbus_wbuf_ctrl_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Power-of-two depth: pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

endmodule

// File: rtl/dbus_wbuf_ctrl.sv
// Data-memory bus controller: posted-write buffer, ACKD_n wait states and bus
// timeout between the pipeline and the external data bus. All bus outputs are registered.
//
//  state   | meaning
//  --------+----------------------------------------------------------------
//  ST_IDLE | bus released (MREQ=0); may issue FIFO head, else a new load
//  ST_BUS  | transaction on the bus; outputs held until ack or timeout
module dbus_wbuf_ctrl
  import dbus_wbuf_ctrl_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int WBUF_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [1:0]                    req_size,
  input  logic [AW-1:0]                 req_addr,
  input  logic [DW-1:0]                 req_wdata,
  output logic                          rsp_valid,
  output logic [DW-1:0]                 rsp_rdata,
  output logic                          bus_err,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_cnt,
  output logic [AW-1:0]                 DAD,
  output logic                          MREQ,
  output logic                          WRITE,
  output logic [1:0]                    SIZE,
  output logic [DW-1:0]                 ddt_o,
  output logic                          ddt_oe,
  input  logic [DW-1:0]                 ddt_i,
  input  logic                          ACKD_n
);

  localparam int EW = AW + DW + 2;
  localparam int TW = wait_width(TIMEOUT);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT);
  localparam logic [TW-1:0] WAIT_ONE  = TW'(1);

  state_t         state_q;
  state_t         state_nxt;
  logic           ld_pend_q;
  logic           ld_pend_nxt;
  logic [TW-1:0]  wait_q;
  logic [TW-1:0]  wait_nxt;

  logic           mreq_nxt;
  logic           write_nxt;
  logic [AW-1:0]  dad_nxt;
  logic [1:0]     size_nxt;
  logic [DW-1:0]  ddt_nxt;
  logic           rsp_valid_nxt;
  logic [DW-1:0]  rsp_rdata_nxt;
  logic           bus_err_nxt;

  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [EW-1:0]  fifo_dout;
  logic [AW-1:0]  head_addr;
  logic [DW-1:0]  head_data;
  logic [1:0]     head_size;

  logic           ld_ready;
  logic           st_acc;
  logic           ld_acc;
  logic           timed_out;

  // Loads only go out on an idle bus with nothing buffered, so they can never
  // overtake a posted store and no read forwarding is required.
  assign ld_ready  = (state_q == ST_IDLE) & fifo_empty & ~ld_pend_q;
  assign req_ready = req_write ? ~fifo_full : ld_ready;
  assign st_acc    = req_valid & req_write & ~fifo_full;
  assign ld_acc    = req_valid & ~req_write & ld_ready;

  dbus_wbuf_ctrl_fifo #(
    .WIDTH (EW),
    .DEPTH (WBUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (st_acc),
    .pop   (fifo_pop),
    .din   ({req_addr, req_wdata, req_size}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (wbuf_cnt)
  );

  assign head_addr = fifo_dout[EW-1 -: AW];
  assign head_data = fifo_dout[DW+1 -: DW];
  assign head_size = fifo_dout[1:0];

  assign timed_out = (TIMEOUT != 0) && (wait_q == WAIT_ONE);

  always_comb begin
    state_nxt     = state_q;
    ld_pend_nxt   = ld_pend_q;
    wait_nxt      = wait_q;
    mreq_nxt      = MREQ;
    write_nxt     = WRITE;
    dad_nxt       = DAD;
    size_nxt      = SIZE;
    ddt_nxt       = ddt_o;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    bus_err_nxt   = 1'b0;
    fifo_pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A store arriving into an empty buffer goes straight out from the
        // request fields; its FIFO copy stays until the bus acknowledges it.
        if (!fifo_empty || st_acc) begin
          state_nxt = ST_BUS;
          mreq_nxt  = 1'b1;
          write_nxt = 1'b1;
          wait_nxt  = WAIT_LOAD;
          dad_nxt   = fifo_empty ? req_addr  : head_addr;
          size_nxt  = fifo_empty ? req_size  : head_size;
          ddt_nxt   = fifo_empty ? req_wdata : head_data;
        end else if (ld_acc) begin
          state_nxt   = ST_BUS;
          ld_pend_nxt = 1'b1;
          mreq_nxt    = 1'b1;
          write_nxt   = 1'b0;
          wait_nxt    = WAIT_LOAD;
          dad_nxt     = req_addr;
          size_nxt    = req_size;
          ddt_nxt     = '0;
        end
      end

      ST_BUS: begin
        // Ack wins over a timeout falling on the same cycle.
        if (!ACKD_n || timed_out) begin
          state_nxt   = ST_IDLE;
          ld_pend_nxt = 1'b0;
          mreq_nxt    = 1'b0;
          write_nxt   = 1'b0;
          dad_nxt     = '0;
          size_nxt    = '0;
          ddt_nxt     = '0;
          bus_err_nxt = ACKD_n;
          if (ld_pend_q) begin
            rsp_valid_nxt = 1'b1;
            rsp_rdata_nxt = ACKD_n ? '0 : ddt_i;
          end else begin
            fifo_pop = 1'b1;
          end
        end else if (TIMEOUT != 0) begin
          wait_nxt = wait_q - WAIT_ONE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ld_pend_q <= 1'b0;
      wait_q    <= '0;
      MREQ      <= 1'b0;
      WRITE     <= 1'b0;
      DAD       <= '0;
      SIZE      <= '0;
      ddt_o     <= '0;
      ddt_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      ld_pend_q <= ld_pend_nxt;
      wait_q    <= wait_nxt;
      MREQ      <= mreq_nxt;
      WRITE     <= write_nxt;
      DAD       <= dad_nxt;
      SIZE      <= size_nxt;
      ddt_o     <= ddt_nxt;
      ddt_oe    <= mreq_nxt & write_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      bus_err   <= bus_err_nxt;
    end
  end

endmodule
